// File: rtl/alu_arb.sv
// alu_arb: two-requester front end for one shared combinational ALU.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop the in-flight operation and return to IDLE
//   rN_req/a/b/op          requester N operation request (held until rN_gnt)
//   rN_gnt                 requester N operands accepted this cycle (comb)
//   rN_rvld/rN_res/rN_rrdy requester N result handshake; res reads 0 when not valid
//   alu_a/alu_b/alu_op     operand and op_ir registers presented to the ALU
//   alu_out                combinational ALU result, captured one cycle after grant
module alu_arb #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned OPW  = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            r0_req,
    input  logic [XLEN-1:0] r0_a,
    input  logic [XLEN-1:0] r0_b,
    input  logic [OPW-1:0]  r0_op,
    output logic            r0_gnt,
    output logic            r0_rvld,
    output logic [XLEN-1:0] r0_res,
    input  logic            r0_rrdy,
    input  logic            r1_req,
    input  logic [XLEN-1:0] r1_a,
    input  logic [XLEN-1:0] r1_b,
    input  logic [OPW-1:0]  r1_op,
    output logic            r1_gnt,
    output logic            r1_rvld,
    output logic [XLEN-1:0] r1_res,
    input  logic            r1_rrdy,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [OPW-1:0]  opc;
    logic [XLEN-1:0] res;
    logic            owner;
    logic            last;

    logic            window;
    logic            grant;
    logic            winner;
    logic            owner_rrdy;

    assign alu_a  = opa;
    assign alu_b  = opb;
    assign alu_op = opc;

    assign owner_rrdy = owner ? r1_rrdy : r0_rrdy;

    // Next state, grant arbitration and response valids
    always_comb begin
        state_nx = state;
        window   = 1'b0;
        grant    = 1'b0;
        winner   = 1'b0;
        r0_gnt   = 1'b0;
        r1_gnt   = 1'b0;
        r0_rvld  = 1'b0;
        r1_rvld  = 1'b0;

        case (state)
            IDLE: window = 1'b1;
            EXEC: state_nx = RESP;
            RESP: begin
                r0_rvld = ~owner;
                r1_rvld = owner;
                if (owner_rrdy) begin
                    window   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Gated by rst_n so no grant leaks out while reset is held
        if (window && rst_n) begin
            // On a tie the requester that did not win last time goes first
            if (r0_req && (!r1_req || last)) begin
                r0_gnt = 1'b1;
                grant  = 1'b1;
                winner = 1'b0;
            end else if (r1_req) begin
                r1_gnt = 1'b1;
                grant  = 1'b1;
                winner = 1'b1;
            end
        end

        if (grant) begin
            state_nx = EXEC;
        end

        if (flush) begin
            r0_gnt   = 1'b0;
            r1_gnt   = 1'b0;
            r0_rvld  = 1'b0;
            r1_rvld  = 1'b0;
            grant    = 1'b0;
            state_nx = IDLE;
        end
    end

    assign r0_res = r0_rvld ? res : '0;
    assign r1_res = r1_rvld ? res : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand latch, ownership and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            opc   <= '0;
            res   <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            if (grant) begin
                opa   <= winner ? r1_a  : r0_a;
                opb   <= winner ? r1_b  : r0_b;
                opc   <= winner ? r1_op : r0_op;
                owner <= winner;
                last  <= winner;
            end
            if (state == EXEC && !flush) begin
                res <= alu_out;
            end
        end
    end

endmodule
